plot_queue: RTL and testbench

Pixel-write buffer between the draw multiplexer and the VGA adapter wrapper. It absorbs bursts of plot requests from the ball, brick, platform and load drawers in a small FIFO. It replays them to the adapter at one plot per non-stalled cycle. It also provides a hardware clear-screen sweep, used on game restart, that paints every pixel of the 160x120 frame with one colour.

---
 rtl/plot_queue.sv | 187 ++++++++++++++++++
 tb/tb_plot_queue.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plot_queue.sv
// plot_queue: pixel-write buffer between the draw multiplexer and the VGA adapter.
// A small FIFO absorbs bursts of plot requests and replays them at one plot per
// non-stalled cycle. A clear request first drains the FIFO, then sweeps every
// pixel of the frame with a fixed colour, then returns to normal operation.
//
//   state | meaning
//   IDLE  | normal operation: pushes accepted, FIFO pops to the adapter
//   DRAIN | clear requested: pushes discarded, FIFO keeps popping until empty
//   SWEEP | FIFO empty: walk (sx,sy) over the frame, one pixel per free cycle
module plot_queue #(
  parameter int unsigned DEPTH        = 16,
  parameter logic [9:0]  X_MAX        = 10'd159,
  parameter logic [9:0]  Y_MAX        = 10'd119,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [9:0]               in_x,
  input  logic [9:0]               in_y,
  input  logic [2:0]               in_colour,
  input  logic                     in_we,
  output logic                     in_ready,
  input  logic                     clear_req,
  output logic                     clear_busy,
  input  logic                     out_stall,
  output logic [9:0]               out_x,
  output logic [9:0]               out_y,
  output logic [2:0]               out_colour,
  output logic                     out_plot,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SWEEP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [9:0]      out_x_q, out_x_d;
  logic [9:0]      out_y_q, out_y_d;
  logic [2:0]      out_colour_q, out_colour_d;
  logic            out_plot_q, out_plot_d;
  logic            overflow_q, overflow_d;
  logic [9:0]      sx_q, sx_d;
  logic [9:0]      sy_q, sy_d;

  // Entry layout: {x, y, colour}
  logic [22:0]     mem_q [DEPTH];

  logic            push;
  logic            pop;
  logic            drop;

  // Acceptance depends only on registered state, so upstream sees no comb path
  // from its own in_we; a pop in the same cycle never makes room at full.
  assign in_ready = (state_q == IDLE) && (count_q < FULL);
  assign push     = in_we && in_ready;
  assign drop     = in_we && (state_q == IDLE) && (count_q == FULL);
  assign pop      = (state_q != SWEEP) && (count_q != '0) && !out_stall;

  assign clear_busy = (state_q != IDLE);
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign out_colour = out_colour_q;
  assign out_plot   = out_plot_q;
  assign count      = count_q;
  assign overflow   = overflow_q;

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_x, in_y, in_colour};
    end
  end

  // Next-state: FIFO pointers/occupancy, sweep walk and registered outputs.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_colour_d = out_colour_q;
    out_plot_d   = 1'b0;
    overflow_d   = overflow_q;
    sx_d         = sx_q;
    sy_d         = sy_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      {out_x_d, out_y_d, out_colour_d} = mem_q[rd_ptr_q];
      out_plot_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (count_q == '0) begin
          state_d = SWEEP;
          sx_d    = '0;
          sy_d    = '0;
        end
      end
      SWEEP: begin
        if (!out_stall) begin
          out_x_d      = sx_q;
          out_y_d      = sy_q;
          out_colour_d = CLEAR_COLOUR;
          out_plot_d   = 1'b1;
          // >= rather than == keeps the walk inside the frame even if a
          // counter were ever disturbed.
          if (sx_q >= X_MAX) begin
            sx_d = '0;
            if (sy_q >= Y_MAX) begin
              sy_d    = '0;
              state_d = IDLE;
            end else begin
              sy_d = sy_q + 1'b1;
            end
          end else begin
            sx_d = sx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_colour_q <= '0;
      out_plot_q   <= 1'b0;
      overflow_q   <= 1'b0;
      sx_q         <= '0;
      sy_q         <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_colour_q <= out_colour_d;
      out_plot_q   <= out_plot_d;
      overflow_q   <= overflow_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
    end
  end

endmodule

// File: tb/tb_plot_queue.sv
// Testbench for plot_queue: randomized stimulus checked every cycle against a
// queue-based reference model, plus directed checks from the test plan.
module tb_plot_queue;

  localparam int MDEPTH = 16;
  localparam int W = 160;
  localparam int H = 120;

  logic       clk;
  logic       resetn;
  logic [9:0] in_x, in_y;
  logic [2:0] in_colour;
  logic       in_we;
  logic       in_ready;
  logic       clear_req;
  logic       clear_busy;
  logic       out_stall;
  logic [9:0] out_x, out_y;
  logic [2:0] out_colour;
  logic       out_plot;
  logic [4:0] count;
  logic       overflow;

  plot_queue dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_colour  (in_colour),
    .in_we      (in_we),
    .in_ready   (in_ready),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .out_stall  (out_stall),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_colour (out_colour),
    .out_plot   (out_plot),
    .count      (count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, mode 0/1/2 = normal/draining/sweeping,
  // sweep position as a linear pixel index over the frame.
  logic [22:0] mq[$];
  int          mode;
  int          idx;
  logic        exp_plot;
  logic [9:0]  ex, ey;
  logic [2:0]  ec;
  logic        e_ovf;

  task automatic model_reset();
    mq.delete();
    mode = 0; idx = 0;
    exp_plot = 0; ex = 0; ey = 0; ec = 0; e_ovf = 0;
  endtask

  task automatic model_step();
    int old_size;
    int old_mode;
    logic [22:0] p;
    old_size = mq.size();
    old_mode = mode;
    exp_plot = 0;
    if (old_mode != 2 && old_size > 0 && !out_stall) begin
      p = mq.pop_front();
      {ex, ey, ec} = p;
      exp_plot = 1;
    end
    if (old_mode == 2 && !out_stall) begin
      ex = 10'(idx % W);
      ey = 10'(idx / W);
      ec = 3'b000;
      exp_plot = 1;
      idx++;
      if (idx == W * H) mode = 0;
    end
    if (in_we && old_mode == 0) begin
      if (old_size < MDEPTH) mq.push_back({in_x, in_y, in_colour});
      else e_ovf = 1;
    end
    if (old_mode == 0 && clear_req) mode = 1;
    if (old_mode == 1 && old_size == 0) begin
      mode = 2;
      idx = 0;
    end
  endtask

  always @(posedge clk) if (resetn) model_step();

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (resetn) begin
      check_eq("plot", out_plot, exp_plot);
      if (exp_plot) begin
        check_eq("out_x", out_x, ex);
        check_eq("out_y", out_y, ey);
        check_eq("out_colour", out_colour, ec);
      end
      check_eq("count", count, mq.size());
      check_eq("in_ready", in_ready, (mode == 0 && mq.size() < MDEPTH));
      check_eq("clear_busy", clear_busy, (mode != 0));
      check_eq("overflow", overflow, e_ovf);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    in_we = 0; in_x = 0; in_y = 0; in_colour = 0; clear_req = 0; out_stall = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    idle_inputs();
    resetn = 0;
    model_reset();
    #1;
    check_eq("rst_plot", out_plot, 0);
    check_eq("rst_x", out_x, 0);
    check_eq("rst_y", out_y, 0);
    check_eq("rst_colour", out_colour, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_busy", clear_busy, 0);
    check_eq("rst_ready", in_ready, 1);
    @(negedge clk);
    #2;
    resetn = 1;
  endtask

  task automatic push_rand();
    in_x = 10'($urandom_range(0, 1023));
    in_y = 10'($urandom_range(0, 1023));
    in_colour = 3'($urandom_range(0, 7));
  endtask

  initial begin
    int plots, first, last, maxc, stall_left;
    bit stalled, check_resume;
    resetn = 0;
    idle_inputs();
    model_reset();
    do_reset();

    // single pixel latency
    @(negedge clk);
    in_x = 10'd5; in_y = 10'd7; in_colour = 3'b100; in_we = 1;
    @(negedge clk);
    in_we = 0;
    @(negedge clk);
    check_eq("lat_plot", out_plot, 1);
    check_eq("lat_x", out_x, 5);
    check_eq("lat_y", out_y, 7);
    check_eq("lat_colour", out_colour, 4);
    @(negedge clk);
    check_eq("lat_plot_off", out_plot, 0);
    check_eq("lat_count", count, 0);

    // fill under stall, overflow, release
    out_stall = 1;
    for (int i = 0; i < 16; i++) begin
      in_x = 10'(i + 1); in_y = 10'(2 * i + 3); in_colour = 3'(i); in_we = 1;
      @(negedge clk);
    end
    in_we = 0;
    check_eq("full_count", count, 16);
    check_eq("full_ready", in_ready, 0);
    in_x = 10'd999; in_y = 10'd999; in_colour = 3'd7; in_we = 1;
    @(negedge clk);
    in_we = 0;
    @(negedge clk);
    check_eq("drop_ovf", overflow, 1);
    check_eq("drop_count", count, 16);
    out_stall = 0;
    plots = 0; first = -1; last = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_plot) begin
        plots++;
        if (first < 0) first = c;
        last = c;
      end
    end
    check_eq("burst_plots", plots, 16);
    check_eq("burst_consecutive", last - first + 1, 16);

    // streaming push/pop
    do_reset();
    maxc = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (count > maxc) maxc = count;
      push_rand();
      in_we = 1;
    end
    @(negedge clk);
    in_we = 0;
    check_eq("stream_maxcount", (maxc <= 1), 1);
    check_eq("stream_ovf", overflow, 0);

    // random mix of pushes and stalls
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      push_rand();
      in_we = 1'($urandom_range(0, 1));
      out_stall = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    idle_inputs();

    // drain then full sweep with a mid-sweep stall at (40,2)
    do_reset();
    out_stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_x = 10'(100 + i); in_y = 10'(50 + i); in_colour = 3'(i + 5); in_we = 1;
    end
    @(negedge clk);
    in_we = 0; out_stall = 0; clear_req = 1;
    @(negedge clk);
    clear_req = 0;
    if (out_plot) plots = 1; else plots = 0;
    stalled = 0; check_resume = 0; stall_left = 0;
    for (int c = 0; c < 25000; c++) begin
      @(negedge clk);
      if (out_plot) begin
        plots++;
        if (check_resume) begin
          check_eq("resume_x", out_x, 40);
          check_eq("resume_y", out_y, 2);
          check_resume = 0;
        end
      end
      if (!clear_busy) break;
      if (!stalled && mode == 2 && idx == 2 * W + 40) begin
        stalled = 1;
        stall_left = 10;
      end
      out_stall = (stall_left > 0);
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) check_resume = 1;
      end
      push_rand();
      in_we = 1'($urandom_range(0, 1));
    end
    idle_inputs();
    check_eq("sweep_done", clear_busy, 0);
    check_eq("sweep_plots", plots, 3 + W * H);
    check_eq("sweep_last_x", out_x, 159);
    check_eq("sweep_last_y", out_y, 119);
    check_eq("sweep_ovf", overflow, 0);
    check_eq("stall_seen", stalled, 1);

    // reset in the middle of a sweep
    @(negedge clk);
    clear_req = 1;
    @(negedge clk);
    clear_req = 0;
    repeat (300) @(negedge clk);
    check_eq("mid_busy", clear_busy, 1);
    do_reset();
    @(negedge clk);
    in_x = 10'd9; in_y = 10'd11; in_colour = 3'b010; in_we = 1;
    @(negedge clk);
    in_we = 0;
    @(negedge clk);
    check_eq("post_plot", out_plot, 1);
    check_eq("post_x", out_x, 9);
    check_eq("post_y", out_y, 11);
    check_eq("post_colour", out_colour, 2);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
